// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package sevenseg_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1110011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Control/data bundle between the BCD source, the scan controller
// and the display pins.
interface sevenseg_scan_ctrl_if
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                          en;
  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] din;
  logic [6:0]                    seg;
  logic [NUM_DIGITS-1:0]         an;
  logic                          frame_tick;
  logic                          bcd_err;

  modport master (
    output en, load, din,
    input  seg, an, frame_tick, bcd_err
  );

  modport slave (
    input  en, load, din,
    output seg, an, frame_tick, bcd_err
  );

endinterface

// File: rtl/bcd_seg_lut.sv
// Combinational BCD to 7-segment decoder.
// Codes above 9 decode dark and raise invalid.
module bcd_seg_lut
  import sevenseg_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg,
  output logic               invalid
);

  always_comb begin
    seg     = SEG_OFF;
    invalid = 1'b0;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multi-digit 7-segment scan controller with blanking gaps.
// Define SEVENSEG_SCAN_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ?
                        SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int WW = DIGIT_W * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  logic [IW-1:0]   idx, nidx;
  logic [WW-1:0]   shadow, active, active_nxt;
  logic            copy, tick, show_nxt, dark;
  logic [DIGIT_W-1:0] digit_nxt;
  logic [6:0]      lut_seg;
  logic            lut_inv;

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  tick_q;
  logic                  err_q;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = idx;
    copy   = 1'b0;
    tick   = 1'b0;
    if (!bus.en) begin
      nstate = IDLE;
      ncnt   = '0;
      nidx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nstate = BLANK;
          ncnt   = '0;
          nidx   = '0;
          copy   = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            nstate = SHOW;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            nstate = BLANK;
            ncnt   = '0;
            if (idx == IDX_LAST) begin
              nidx = '0;
              tick = 1'b1;
              copy = 1'b1;
            end else begin
              nidx = idx + 1'b1;
            end
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: begin
          nstate = IDLE;
          ncnt   = '0;
          nidx   = '0;
        end
      endcase
    end
  end

  // A load landing on the frame copy bypasses shadow
  always_comb begin
    active_nxt = active;
    if (copy) active_nxt = bus.load ? bus.din : shadow;
  end

  assign show_nxt  = (nstate == SHOW);
  assign digit_nxt = active_nxt[DIGIT_W*int'(nidx) +: DIGIT_W];

  bcd_seg_lut u_lut (
    .code    (digit_nxt),
    .seg     (lut_seg),
    .invalid (lut_inv)
  );

`ifdef SEVENSEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz;

  // lz[k]: digit k and every more-significant digit are zero
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] =
      (active_nxt[WW-1 -: DIGIT_W] == '0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] &
        (active_nxt[DIGIT_W*k +: DIGIT_W] == '0);
    end
  end

  assign dark = (nidx != '0) && lz[nidx];
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      active <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      idx    <= nidx;
      active <= active_nxt;
      tick_q <= tick;
      if (bus.load) shadow <= bus.din;
      an_q  <= show_nxt ? (AN_ONE << nidx) : '0;
      seg_q <= (show_nxt && !dark) ? lut_seg : SEG_OFF;
      err_q <= (err_q & ~bus.load) | (show_nxt & lut_inv);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;
  assign bus.bcd_err    = err_q;

endmodule
